// File: rtl/mfm_decoder.sv
// MFM read-channel decoder: resynchronises the raw pulse stream and the recovered
// cell clock, hunts for the A1 sync mark, then emits one decoded byte per 16 cells.
module mfm_decoder #(
  parameter logic [15:0] SYNC_WORD   = 16'h4489,
  parameter int          FRAME_BYTES = 512
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       raw_mfm,
  input  logic       clk_5,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       sync_found,
  output logic       mfm_error,
  output logic       in_frame
);
  typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

  localparam logic [15:0] FRAME_LIMIT = 16'(FRAME_BYTES);

  state_t      state, state_nxt;
  logic        raw_s1, raw_s2, raw_prev;
  logic        clk5_s1, clk5_s2, clk5_prev;
  logic        pulse_latch;
  logic [15:0] cell_reg, cell_nxt;
  logic [3:0]  cell_cnt, cell_cnt_nxt;
  logic [15:0] byte_cnt, byte_cnt_nxt;
  logic        prev_one, prev_one_nxt;
  logic [1:0]  zero_run, zero_run_nxt;
  logic [7:0]  data_nxt;
  logic        dv_nxt, sync_nxt, err_nxt;
  logic        frame_done, done_nxt;
  logic        boundary, raw_rise, sync_hit, code_err, byte_done, last_byte;
  logic        unused_cell_msb;

  // The oldest cell only ages out of the register; every check looks at the shifted value.
  assign unused_cell_msb = cell_reg[15];

  assign boundary  = clk5_s2 & ~clk5_prev;
  assign raw_rise  = raw_s2 & ~raw_prev;
  assign cell_nxt  = {cell_reg[14:0], pulse_latch};
  assign sync_hit  = (cell_nxt == SYNC_WORD);
  // Run-length checks only span cells accepted since the last sync mark.
  assign code_err  = pulse_latch ? prev_one : (zero_run == 2'd3);
  assign byte_done = (cell_cnt == 4'd15);
  assign last_byte = (FRAME_BYTES != 0) && ((byte_cnt + 16'd1) == FRAME_LIMIT);
  assign in_frame  = (state == DATA);

  // data_valid is a one-cycle strobe with no back-pressure; data holds between strobes.
  always_comb begin
    state_nxt    = state;
    cell_cnt_nxt = cell_cnt;
    byte_cnt_nxt = byte_cnt;
    prev_one_nxt = prev_one;
    zero_run_nxt = zero_run;
    data_nxt     = data;
    dv_nxt       = 1'b0;
    sync_nxt     = 1'b0;
    err_nxt      = 1'b0;
    done_nxt     = 1'b0;
    if (frame_done) begin
      state_nxt = HUNT;
    end else if (boundary) begin
      if (sync_hit) begin
        sync_nxt     = 1'b1;
        state_nxt    = DATA;
        cell_cnt_nxt = 4'd0;
        byte_cnt_nxt = 16'd0;
        prev_one_nxt = 1'b0;
        zero_run_nxt = 2'd0;
      end else if (state == DATA) begin
        if (code_err) begin
          err_nxt   = 1'b1;
          state_nxt = HUNT;
        end else begin
          cell_cnt_nxt = cell_cnt + 4'd1;
          prev_one_nxt = pulse_latch;
          zero_run_nxt = pulse_latch ? 2'd0 : zero_run + 2'd1;
          if (byte_done) begin
            dv_nxt       = 1'b1;
            data_nxt     = {cell_nxt[14], cell_nxt[12], cell_nxt[10], cell_nxt[8],
                            cell_nxt[6], cell_nxt[4], cell_nxt[2], cell_nxt[0]};
            byte_cnt_nxt = byte_cnt + 16'd1;
            done_nxt     = last_byte;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      raw_s1      <= 1'b0;
      raw_s2      <= 1'b0;
      raw_prev    <= 1'b0;
      clk5_s1     <= 1'b0;
      clk5_s2     <= 1'b0;
      clk5_prev   <= 1'b0;
      pulse_latch <= 1'b0;
      cell_reg    <= 16'd0;
    end else begin
      raw_s1    <= raw_mfm;
      raw_s2    <= raw_s1;
      raw_prev  <= raw_s2;
      clk5_s1   <= clk_5;
      clk5_s2   <= clk5_s1;
      clk5_prev <= clk5_s2;
      // A pulse seen in the boundary cycle itself belongs to the next cell.
      if (boundary) begin
        cell_reg    <= cell_nxt;
        pulse_latch <= raw_rise;
      end else if (raw_rise) begin
        pulse_latch <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      cell_cnt   <= 4'd0;
      byte_cnt   <= 16'd0;
      prev_one   <= 1'b0;
      zero_run   <= 2'd0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      sync_found <= 1'b0;
      mfm_error  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cell_cnt   <= cell_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      prev_one   <= prev_one_nxt;
      zero_run   <= zero_run_nxt;
      data       <= data_nxt;
      data_valid <= dv_nxt;
      sync_found <= sync_nxt;
      mfm_error  <= err_nxt;
      frame_done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_mfm_decoder.sv
// Bench for mfm_decoder: drives cell-aligned MFM streams with jittered pulses and compares
// every cycle against a cell-level model built from the decoding rules.
module tb_mfm_decoder;
  localparam logic [15:0] SYNC = 16'h4489;
  localparam int FB = 2;

  // clock / reset
  logic clk_50 = 1'b0;
  logic reset, raw_mfm, clk_5;
  logic [7:0] data;
  logic data_valid, sync_found, mfm_error, in_frame;

  always #10 clk_50 = ~clk_50;

  mfm_decoder #(.SYNC_WORD(SYNC), .FRAME_BYTES(FB)) dut (
    .clk_50(clk_50), .reset(reset), .raw_mfm(raw_mfm), .clk_5(clk_5),
    .data(data), .data_valid(data_valid), .sync_found(sync_found),
    .mfm_error(mfm_error), .in_frame(in_frame)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  int dv_seen = 0, sync_seen = 0, err_seen = 0;
  logic [7:0] last_dv_data = 8'h00;
  logic [7:0] exp_q[$];
  logic check_en = 1'b0;
  logic [7:0] exp_data;
  logic exp_dv, exp_sync, exp_err, exp_in_frame;

  // model state
  bit cell_hist[$];
  bit frame_cells[$];
  bit m_in_frame, done_pending;
  int m_bytes;
  bit stim_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mfm_enc(input logic [7:0] b, input logic prev);
    logic p;
    logic [15:0] w;
    p = prev;
    w = 16'h0000;
    for (int i = 7; i >= 0; i--) begin
      w = {w[13:0], ~p & ~b[i], b[i]};
      p = b[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    cell_hist.delete();
    for (int i = 0; i < 16; i++) cell_hist.push_back(1'b0);
    frame_cells.delete();
    exp_q.delete();
    m_in_frame = 0; done_pending = 0; m_bytes = 0;
    exp_data = 8'h00; exp_dv = 0; exp_sync = 0; exp_err = 0; exp_in_frame = 0;
  endtask

  // One cell: last 16 cells matching the mark restart a frame; otherwise, inside a frame,
  // an adjacent pair of 1s or a fourth 0 aborts, and every 16th accepted cell yields a byte.
  task automatic model_step(input bit b);
    logic [15:0] w;
    logic [7:0] v;
    int n;
    bit bad;
    cell_hist.push_back(b);
    void'(cell_hist.pop_front());
    w = 16'h0000;
    foreach (cell_hist[i]) w = {w[14:0], cell_hist[i]};
    if (w == SYNC) begin
      exp_sync = 1; m_in_frame = 1; m_bytes = 0;
      frame_cells.delete();
    end else if (m_in_frame) begin
      n = frame_cells.size();
      bad = 0;
      if (b && n >= 1 && frame_cells[n-1]) bad = 1;
      if (!b && n >= 3 && !frame_cells[n-1] && !frame_cells[n-2] && !frame_cells[n-3]) bad = 1;
      if (bad) begin
        exp_err = 1; m_in_frame = 0;
      end else begin
        frame_cells.push_back(b);
        n = frame_cells.size();
        if (n % 16 == 0) begin
          for (int k = 0; k < 8; k++) v[7-k] = frame_cells[n-16+2*k+1];
          exp_dv = 1; exp_data = v; exp_q.push_back(v);
          m_bytes++;
          if (FB != 0 && m_bytes == FB) done_pending = 1;
        end
      end
    end
    exp_in_frame = m_in_frame;
  endtask

  // driver tasks
  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) stim_q.push_back(w[i]);
  endtask

  // Each cell is 10 clk_50 cycles: clk_5 low for 5, high for 5. A 1 cell gets one pulse,
  // either early in its own window or late in the previous window (after that boundary).
  task automatic play();
    bit wave[$];
    int n, off, wid, base;
    n = stim_q.size();
    for (int i = 0; i < n * 10; i++) wave.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (stim_q[i]) begin
        if (i > 0 && $urandom_range(0, 3) == 0) off = -5 + int'($urandom_range(0, 1));
        else off = int'($urandom_range(0, 2));
        wid = int'($urandom_range(1, 2));
        base = i * 10 + off;
        for (int w = 0; w < wid; w++) wave[base + w] = 1'b1;
      end
    end
    for (int c = 0; c < n * 10; c++) begin
      @(posedge clk_50); #1;
      raw_mfm = wave[c];
      clk_5 = ((c % 10) >= 5);
      exp_dv = 0; exp_sync = 0; exp_err = 0;
      if (c % 10 == 8) model_step(stim_q[c / 10]);
      if (c % 10 == 9 && done_pending) begin
        m_in_frame = 0; exp_in_frame = 0; done_pending = 0;
      end
    end
    stim_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk_50); #1;
    reset = 1; raw_mfm = 0; clk_5 = 0;
    model_reset();
    check_en = 1;
    repeat (3) begin @(posedge clk_50); #1; end
    chk("rst_data", int'(data), 0);
    chk("rst_in_frame", int'(in_frame), 0);
    reset = 0;
  endtask

  // compare process
  always @(negedge clk_50) begin
    if (check_en) begin
      chk("data", int'(data), int'(exp_data));
      chk("data_valid", int'(data_valid), int'(exp_dv));
      chk("sync_found", int'(sync_found), int'(exp_sync));
      chk("mfm_error", int'(mfm_error), int'(exp_err));
      chk("in_frame", int'(in_frame), int'(exp_in_frame));
      if (data_valid) begin
        dv_seen++;
        last_dv_data = data;
        if (exp_q.size() == 0) chk("unexpected_byte", int'(data), -1);
        else chk("byte_q", int'(data), int'(exp_q.pop_front()));
      end
      if (sync_found) sync_seen++;
      if (mfm_error) err_seen++;
    end
  end

  initial begin
    int s0, d0, e0, gap, nb, start, pos;
    logic [7:0] b;
    logic prev;
    reset = 1; raw_mfm = 0; clk_5 = 0;
    model_reset();
    repeat (2) @(posedge clk_50);
    chk("enc_4e", int'(mfm_enc(8'h4E, 1'b0)), 16'h9254);
    chk("enc_00", int'(mfm_enc(8'h00, 1'b1)), 16'h2AAA);

    // sync detect
    apply_reset();
    s0 = sync_seen; d0 = dv_seen;
    push_word(SYNC); play();
    chk("t_sync_cnt", sync_seen - s0, 1);
    chk("t_sync_dv", dv_seen - d0, 0);
    chk("t_sync_in_frame", int'(in_frame), 1);

    // byte decode
    d0 = dv_seen;
    push_word(16'h9254); play();
    chk("t_byte_cnt", dv_seen - d0, 1);
    chk("t_byte_val", int'(last_dv_data), 8'h4E);

    // coding error, then data ignored
    e0 = err_seen;
    stim_q.push_back(1'b1); stim_q.push_back(1'b1); play();
    chk("t_err_cnt", err_seen - e0, 1);
    chk("t_err_in_frame", int'(in_frame), 0);
    d0 = dv_seen;
    push_word(16'h9254); play();
    chk("t_err_no_dv", dv_seen - d0, 0);

    // frame end after two bytes
    apply_reset();
    d0 = dv_seen;
    push_word(SYNC);
    push_word(mfm_enc(8'h12, 1'b1));
    push_word(mfm_enc(8'h34, 1'b0));
    push_word(mfm_enc(8'h56, 1'b0));
    play();
    chk("t_frame_dv", dv_seen - d0, 2);
    chk("t_frame_last", int'(last_dv_data), 8'h34);
    chk("t_frame_in_frame", int'(in_frame), 0);

    // re-sync after 8 data cells
    apply_reset();
    s0 = sync_seen; d0 = dv_seen;
    push_word(SYNC);
    for (int i = 7; i >= 0; i--) stim_q.push_back(mfm_enc(8'h4E, 1'b0)[8 + i]);
    push_word(SYNC);
    push_word(16'h9254);
    play();
    chk("t_resync_sync", sync_seen - s0, 2);
    chk("t_resync_dv", dv_seen - d0, 2);
    chk("t_resync_byte", int'(last_dv_data), 8'h4E);

    // sync on the final-byte boundary keeps the frame open
    apply_reset();
    s0 = sync_seen; d0 = dv_seen;
    push_word(SYNC); push_word(16'h9254); push_word(SYNC); play();
    chk("t_prio_sync", sync_seen - s0, 2);
    chk("t_prio_dv", dv_seen - d0, 1);
    chk("t_prio_in_frame", int'(in_frame), 1);

    // reset mid-byte
    apply_reset();
    push_word(SYNC);
    for (int i = 15; i >= 6; i--) stim_q.push_back(mfm_enc(8'hA5, 1'b1)[i]);
    play();
    apply_reset();
    s0 = sync_seen; d0 = dv_seen;
    push_word(16'h9254); play();
    chk("t_rst_dv", dv_seen - d0, 0);
    chk("t_rst_sync", sync_seen - s0, 0);
    chk("t_rst_data", int'(data), 0);
    chk("t_rst_in_frame", int'(in_frame), 0);

    // randomized frames
    for (int it = 0; it < 30; it++) begin
      gap = int'($urandom_range(0, 12));
      for (int i = 0; i < gap; i++) stim_q.push_back(1'($urandom_range(0, 1)));
      start = stim_q.size();
      push_word(SYNC);
      nb = int'($urandom_range(1, 3));
      prev = 1'b1;
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom_range(0, 255));
        push_word(mfm_enc(b, prev));
        prev = b[0];
      end
      if ($urandom_range(0, 5) == 0) begin
        pos = start + 16 + int'($urandom_range(0, nb * 16 - 2));
        stim_q[pos] = 1'b1;
        stim_q[pos + 1] = 1'b1;
      end
      play();
      if ($urandom_range(0, 7) == 0) apply_reset();
    end

    repeat (4) @(posedge clk_50);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mfm_decoder.md
MFM_DECODER -- requirements
Module: mfm_decoder

Parameters
REQ-001 SYNC_WORD, 16'h4489, MFM cell pattern of the A1 sync mark (missing clock bit).
REQ-002 FRAME_BYTES, 512, number of bytes delivered after a sync before the block returns to HUNT; 0 = unlimited.

Interface
REQ-003 clk_50  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 raw_mfm  input  1  raw MFM pulse stream, asynchronous to clk_50.
REQ-006 clk_5  input  1  recovered 5 MHz cell clock from the DPLL, sampled as data in the clk_50 domain.
REQ-007 data  output  8  decoded byte, MSB first on disk.
REQ-008 data_valid  output  1  one-cycle strobe; data is valid in the same cycle.
REQ-009 sync_found  output  1  one-cycle strobe on sync-mark detection.
REQ-010 mfm_error  output  1  one-cycle strobe on an MFM coding violation.
REQ-011 in_frame  output  1  high while the state is DATA.

Function
REQ-012 raw_mfm and clk_5 SHALL each pass through a 2-flop synchronizer before use.
REQ-013 A cell boundary SHALL be the cycle in which synchronized clk_5 is 1 and its previous sample is 0.
REQ-014 A pulse latch SHALL set on a synchronized raw_mfm rising edge; a rising edge detected in a boundary cycle SHALL count toward the following cell.
REQ-015 At each boundary the latch value SHALL shift into bit 0 of a 16-bit cell register (shift left), and the latch SHALL clear.
REQ-016 States SHALL be HUNT, DATA. Reset state: HUNT.
REQ-017 HUNT: when the cell register equals SYNC_WORD after a boundary shift, the block SHALL pulse sync_found on the next cycle, clear the cell counter and byte counter, and enter DATA.
REQ-018 DATA: a 4-bit cell counter SHALL count boundaries. On the 16th cell, data SHALL take cell register bits 14,12,10,8,6,4,2,0 as data[7:0], and data_valid SHALL pulse one cycle after that boundary.
REQ-019 DATA: a cell register equal to SYNC_WORD SHALL re-align. It pulses sync_found, restarts the cell and byte counters, and emits no data_valid for that word.
REQ-020 DATA: two consecutive 1 cells, or a run of more than 3 consecutive 0 cells, SHALL pulse mfm_error one cycle after the offending boundary and return the state to HUNT.
REQ-021 DATA: when FRAME_BYTES is nonzero and the byte counter reaches FRAME_BYTES, the state SHALL return to HUNT in the cycle after the final data_valid.
REQ-022 If the sync match and the final-byte condition occur at the same boundary, the sync match SHALL take priority: the state stays in DATA and the counters restart.
REQ-023 data SHALL hold its last value between strobes.
REQ-024 The cell-register checks SHALL be evaluated once per boundary and never in non-boundary cycles.

Reset
REQ-025 While reset is high, the following SHALL hold asynchronously:
- state = HUNT;
- cell register, counters, pulse latch and synchronizers = 0;
- data = 8'h00;
- data_valid, sync_found, mfm_error and in_frame = 0.
REQ-026 Reset asserted mid-byte SHALL discard the partial byte, and no strobe SHALL fire on release.
REQ-027 After reset release, the block SHALL require a fresh SYNC_WORD match before any data_valid.

Verification
REQ-028 Sync detect: after reset, drive the cells 0x4489 aligned to clk_5 -> exactly one sync_found; in_frame=1; no data_valid.
REQ-029 Byte decode: sync then the cells for 0x4E (MFM 0x9254) -> data=8'h4E with a single data_valid pulse, 16 boundaries after the sync.
REQ-030 Error: in DATA, drive the cells 1,1 -> mfm_error pulse; in_frame=0; a following 0x9254 yields no data_valid.
REQ-031 Frame end: FRAME_BYTES=2, sync plus 3 bytes -> exactly 2 data_valid pulses, then in_frame=0.
REQ-032 Re-sync: sync, 8 data cells, then 0x4489 -> second sync_found; the next 16 cells decode as a full byte.
REQ-033 Reset mid-byte: assert reset after 10 data cells, release, then drive 0x9254 without a sync -> no data_valid, and all outputs 0.
